// File: rtl/tl_ctrl_pkg.sv
// tl_ctrl_pkg: shared definitions for the traffic-light controller.
//   STATE_W            width of the one-hot phase vector driven to dp
//   S_INIT/S_G/S_Y/S_R bit index of each phase inside that vector
//   CNT_W              width of phase-cycle counters
//   state_e            one-hot phase encoding (ST_* are the vector constants)
//   next_state()       normal phase successor, INIT -> G -> Y -> R -> G
package tl_ctrl_pkg;
  localparam int STATE_W = 4;
  localparam int S_INIT  = 0;
  localparam int S_G     = 1;
  localparam int S_Y     = 2;
  localparam int S_R     = 3;
  localparam int CNT_W   = 11;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT = 4'b0001,
    ST_G    = 4'b0010,
    ST_Y    = 4'b0100,
    ST_R    = 4'b1000
  } state_e;

  // INIT only ever leads to G; R closes the loop back to G.
  function automatic state_e next_state(input state_e s);
    case (s)
      ST_G:    next_state = ST_Y;
      ST_Y:    next_state = ST_R;
      default: next_state = ST_G;
    endcase
  endfunction
endpackage

// File: rtl/tl_ctrl_if.sv
// tl_ctrl_if: handshake bundle between top-level ports/dp and tl_ctrl.
//   master: drives hold, int_flags (and ped_req); observes the rest
//   slave : tl_ctrl side; drives state, cnt_rst, fault, cyc_cnt (and ped_ack)
// Optional pedestrian signals exist only when TL_PED_REQ_EN is defined.
interface tl_ctrl_if #(parameter int CYC_W = 8);
  import tl_ctrl_pkg::*;
  logic               hold;
  logic [STATE_W-1:0] int_flags;
  logic [STATE_W-1:0] state;
  logic               cnt_rst;
  logic               fault;
  logic [CYC_W-1:0]   cyc_cnt;
`ifdef TL_PED_REQ_EN
  logic               ped_req;
  logic               ped_ack;
`endif

  modport master (
    output hold, int_flags,
`ifdef TL_PED_REQ_EN
    output ped_req,
    input  ped_ack,
`endif
    input  state, cnt_rst, fault, cyc_cnt
  );

  modport slave (
    input  hold, int_flags,
`ifdef TL_PED_REQ_EN
    input  ped_req,
    output ped_ack,
`endif
    output state, cnt_rst, fault, cyc_cnt
  );
endinterface

// File: rtl/tl_wdog.sv
// tl_wdog: per-phase watchdog counter.
//   clk, reset : clock, async active-high reset
//   en         : count this cycle
//   clr        : restart the phase count (wins over en)
//   expire     : count has reached WDOG_MAX-1
module tl_wdog #(
  parameter int WDOG_MAX = 2047
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int W = (WDOG_MAX > 2) ? $clog2(WDOG_MAX) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  // Parent clears on expiry, so the count never needs to exceed WDOG_MAX-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign expire = (cnt_q == W'(WDOG_MAX - 1));
endmodule

// File: rtl/tl_ctrl.sv
// tl_ctrl: sequencing FSM for the traffic-light datapath.
//   clk, reset : clock, async active-high reset (returns to INIT)
//   bus        : tl_ctrl_if.slave
//     hold      freeze sequencing and watchdog
//     int_flags per-phase done flags from dp; only the current phase's bit counts
//     state     one-hot phase to dp
//     cnt_rst   one-cycle pulse on every phase change
//     fault     sticky watchdog fault (parks in R)
//     cyc_cnt   completed R->G cycles, wrapping
//     ped_req/ped_ack  pedestrian request/serve pulse
// Optional feature macro: TL_PED_REQ_EN (pedestrian early end of G).
module tl_ctrl
  import tl_ctrl_pkg::*;
#(
  parameter int WDOG_MAX  = 2047,
  parameter int CYC_W     = 8
`ifdef TL_PED_REQ_EN
  , parameter int PED_MIN_G = 128
`endif
) (
  input  logic         clk,
  input  logic         reset,
  tl_ctrl_if.slave     bus
);
  state_e           state_q, state_d;
  logic             cnt_rst_q, cnt_rst_d;
  logic             blank_q, blank_d;
  logic             fault_q, fault_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             go, adv, trip, expire;

  // blank masks the flags for the cycle after a transition, since dp's
  // flag for the old phase may still be asserted while its counter clears.
  assign go = ~blank_q & ~bus.hold & ~fault_q;

`ifdef TL_PED_REQ_EN
  logic             ped_pend_q, ped_pend_d;
  logic             ped_ack_q, ped_ack_d;
  logic [CNT_W-1:0] ped_cnt_q, ped_cnt_d;
  logic             ped_early, serve;

  assign ped_early = (state_q == ST_G) & ped_pend_q & (ped_cnt_q >= CNT_W'(PED_MIN_G));
  assign adv       = go & ((|(bus.int_flags & state_q)) | ped_early);
  assign serve     = adv & (state_q == ST_Y);

  always_comb begin
    ped_cnt_d  = ped_cnt_q;
    ped_ack_d  = serve & ped_pend_q;
    // A request level on the serving edge re-arms immediately.
    ped_pend_d = (ped_pend_q & ~serve) | bus.ped_req;
    if (adv && next_state(state_q) == ST_G)
      ped_cnt_d = '0;
    else if (state_q == ST_G && ped_cnt_q < CNT_W'(PED_MIN_G))
      ped_cnt_d = ped_cnt_q + 1'b1;  // saturates at the threshold
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
      ped_cnt_q  <= '0;
    end else begin
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= ped_ack_d;
      ped_cnt_q  <= ped_cnt_d;
    end

  assign bus.ped_ack = ped_ack_q;
`else
  assign adv = go & (|(bus.int_flags & state_q));
`endif

  // Advance beats the watchdog when both land on the same edge.
  assign trip = expire & ~fault_q & ~adv;

  tl_wdog #(.WDOG_MAX(WDOG_MAX)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .en     (~bus.hold & ~fault_q & ~adv),
    .clr    (adv | trip),
    .expire (expire)
  );

  always_comb begin
    state_d   = state_q;
    cnt_rst_d = 1'b0;
    blank_d   = 1'b0;
    fault_d   = fault_q;
    cyc_d     = cyc_q;
    if (adv) begin
      state_d   = next_state(state_q);
      cnt_rst_d = 1'b1;
      blank_d   = 1'b1;
      if (state_q == ST_R) cyc_d = cyc_q + 1'b1;
    end else if (trip) begin
      state_d   = ST_R;
      cnt_rst_d = 1'b1;
      blank_d   = 1'b1;
      fault_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_rst_q <= 1'b0;
      blank_q   <= 1'b0;
      fault_q   <= 1'b0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_rst_q <= cnt_rst_d;
      blank_q   <= blank_d;
      fault_q   <= fault_d;
      cyc_q     <= cyc_d;
    end

  assign bus.state   = state_q;
  assign bus.cnt_rst = cnt_rst_q;
  assign bus.fault   = fault_q;
  assign bus.cyc_cnt = cyc_q;
endmodule

// File: tb/tb_tl_ctrl.sv
// tb_tl_ctrl: directed bench for tl_ctrl with WDOG_MAX=16, CYC_W=2.
module tb_tl_ctrl;
  import tl_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses = 0;
  int   p0;

  always #5 clk = ~clk;

  tl_ctrl_if #(.CYC_W(2)) bus();

  tl_ctrl #(
    .WDOG_MAX (16),
    .CYC_W    (2)
`ifdef TL_PED_REQ_EN
    , .PED_MIN_G(8)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // cnt_rst is registered on posedge; sampling at posedge sees the settled pulse.
  always @(posedge clk) if (bus.cnt_rst === 1'b1) pulses <= pulses + 1;

  task automatic pulse_flag(input int idx);
    bus.int_flags = 4'(1 << idx);
    @(negedge clk);
    bus.int_flags = '0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.state !== 4'b0001) begin n_bad++; $display("FAIL reset_state got %b want 0001", bus.state); end
    n_cmp++; if (bus.cnt_rst !== 1'b0) begin n_bad++; $display("FAIL reset_cnt_rst got %b want 0", bus.cnt_rst); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b want 0", bus.fault); end
    n_cmp++; if (bus.cyc_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_cyc got %0d want 0", bus.cyc_cnt); end
`ifdef TL_PED_REQ_EN
    n_cmp++; if (bus.ped_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ped_ack got %b want 0", bus.ped_ack); end
`endif
    reset = 1'b0;
    p0 = pulses;
  endtask

  task automatic test_basic;
    repeat (9) @(negedge clk);
    bus.int_flags = 4'b0011;            // INIT flag plus G flag already high
    @(negedge clk);
    n_cmp++; if (bus.state !== 4'b0010) begin n_bad++; $display("FAIL basic_state got %b want 0010", bus.state); end
    n_cmp++; if (bus.cnt_rst !== 1'b1) begin n_bad++; $display("FAIL basic_cnt_rst got %b want 1", bus.cnt_rst); end
    bus.int_flags = 4'b0010;            // held through blank cycle
    @(negedge clk);
    n_cmp++; if (bus.state !== 4'b0010) begin n_bad++; $display("FAIL blank_state got %b want 0010", bus.state); end
    n_cmp++; if (bus.cnt_rst !== 1'b0) begin n_bad++; $display("FAIL blank_cnt_rst got %b want 0", bus.cnt_rst); end
    bus.int_flags = 4'b1100;            // flags of other phases
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.state !== 4'b0010) begin n_bad++; $display("FAIL other_flags_state got %b want 0010", bus.state); end
    bus.int_flags = '0;
  endtask

  task automatic test_full_cycle;
    for (int c = 0; c < 3; c++)
      for (int s = 1; s <= 3; s++) begin
        repeat (3) @(negedge clk);
        pulse_flag(s);
      end
    @(negedge clk);
    n_cmp++; if (pulses - p0 !== 10) begin n_bad++; $display("FAIL full_pulses got %0d want 10", pulses - p0); end
    n_cmp++; if (bus.cyc_cnt !== 2'd3) begin n_bad++; $display("FAIL full_cyc got %0d want 3", bus.cyc_cnt); end
    n_cmp++; if (bus.state !== 4'b0010) begin n_bad++; $display("FAIL full_state got %b want 0010", bus.state); end
    for (int c = 0; c < 2; c++)
      for (int s = 1; s <= 3; s++) begin
        repeat (3) @(negedge clk);
        pulse_flag(s);
      end
    @(negedge clk);
    n_cmp++; if (bus.cyc_cnt !== 2'd1) begin n_bad++; $display("FAIL wrap_cyc got %0d want 1", bus.cyc_cnt); end
    n_cmp++; if (pulses - p0 !== 16) begin n_bad++; $display("FAIL wrap_pulses got %0d want 16", pulses - p0); end
  endtask

  task automatic test_hold;
    repeat (2) @(negedge clk);
    pulse_flag(S_G);
    n_cmp++; if (bus.state !== 4'b0100) begin n_bad++; $display("FAIL hold_enter_y got %b want 0100", bus.state); end
    @(negedge clk);
    bus.hold = 1'b1;
    bus.int_flags = 4'b0100;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.state !== 4'b0100) begin n_bad++; $display("FAIL hold_state got %b want 0100", bus.state); end
    n_cmp++; if (bus.cnt_rst !== 1'b0) begin n_bad++; $display("FAIL hold_cnt_rst got %b want 0", bus.cnt_rst); end
    bus.hold = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.state !== 4'b1000) begin n_bad++; $display("FAIL unhold_state got %b want 1000", bus.state); end
    n_cmp++; if (bus.cnt_rst !== 1'b1) begin n_bad++; $display("FAIL unhold_cnt_rst got %b want 1", bus.cnt_rst); end
    bus.int_flags = '0;
  endtask

  task automatic test_watchdog;
    @(negedge clk);
    pulse_flag(S_R);
    n_cmp++; if (bus.cyc_cnt !== 2'd2) begin n_bad++; $display("FAIL wd_pre_cyc got %0d want 2", bus.cyc_cnt); end
    repeat (15) @(negedge clk);
    n_cmp++; if (bus.fault !== 1'b0 || bus.state !== 4'b0010) begin n_bad++; $display("FAIL wd_early fault=%b state=%b want 0 0010", bus.fault, bus.state); end
    @(negedge clk);
    n_cmp++; if (bus.fault !== 1'b1) begin n_bad++; $display("FAIL wd_fault got %b want 1", bus.fault); end
    n_cmp++; if (bus.state !== 4'b1000) begin n_bad++; $display("FAIL wd_state got %b want 1000", bus.state); end
    n_cmp++; if (bus.cnt_rst !== 1'b1) begin n_bad++; $display("FAIL wd_cnt_rst got %b want 1", bus.cnt_rst); end
    @(negedge clk);
    n_cmp++; if (bus.cnt_rst !== 1'b0) begin n_bad++; $display("FAIL wd_cnt_rst_end got %b want 0", bus.cnt_rst); end
    bus.int_flags = 4'b1000;
    @(negedge clk);
    bus.int_flags = 4'b0010;
    @(negedge clk);
    bus.int_flags = '0;
    @(negedge clk);
    n_cmp++; if (bus.state !== 4'b1000 || bus.fault !== 1'b1) begin n_bad++; $display("FAIL wd_sticky state=%b fault=%b want 1000 1", bus.state, bus.fault); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.fault !== 1'b0 || bus.state !== 4'b0001) begin n_bad++; $display("FAIL wd_reset fault=%b state=%b want 0 0001", bus.fault, bus.state); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_simultaneous;
    repeat (2) @(negedge clk);
    pulse_flag(S_INIT);
    repeat (15) @(negedge clk);
    bus.int_flags = 4'b0010;            // lands on the watchdog-limit edge
    @(negedge clk);
    bus.int_flags = '0;
    n_cmp++; if (bus.state !== 4'b0100) begin n_bad++; $display("FAIL sim_state got %b want 0100", bus.state); end
    n_cmp++; if (bus.fault !== 1'b0) begin n_bad++; $display("FAIL sim_fault got %b want 0", bus.fault); end
    @(negedge clk); pulse_flag(S_Y);
    @(negedge clk); pulse_flag(S_R);
    n_cmp++; if (bus.cyc_cnt !== 2'd1) begin n_bad++; $display("FAIL sim_cyc got %0d want 1", bus.cyc_cnt); end
    @(negedge clk); pulse_flag(S_G);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.state !== 4'b0001) begin n_bad++; $display("FAIL midy_reset_state got %b want 0001", bus.state); end
    n_cmp++; if (bus.cyc_cnt !== 2'd0) begin n_bad++; $display("FAIL midy_reset_cyc got %0d want 0", bus.cyc_cnt); end
    n_cmp++; if (bus.cnt_rst !== 1'b0) begin n_bad++; $display("FAIL midy_reset_cnt_rst got %b want 0", bus.cnt_rst); end
    @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef TL_PED_REQ_EN
  task automatic test_ped;
    repeat (2) @(negedge clk);
    pulse_flag(S_INIT);
    @(negedge clk);
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (bus.state !== 4'b0010) begin n_bad++; $display("FAIL ped_still_g got %b want 0010", bus.state); end
    @(negedge clk);
    n_cmp++; if (bus.state !== 4'b0100) begin n_bad++; $display("FAIL ped_early_y got %b want 0100", bus.state); end
    @(negedge clk);
    pulse_flag(S_Y);
    n_cmp++; if (bus.ped_ack !== 1'b1) begin n_bad++; $display("FAIL ped_ack got %b want 1", bus.ped_ack); end
    @(negedge clk);
    n_cmp++; if (bus.ped_ack !== 1'b0) begin n_bad++; $display("FAIL ped_ack_end got %b want 0", bus.ped_ack); end
    pulse_flag(S_R);
    repeat (11) @(negedge clk);
    n_cmp++; if (bus.state !== 4'b0010) begin n_bad++; $display("FAIL ped_noreq_g got %b want 0010", bus.state); end
    pulse_flag(S_G);
    n_cmp++; if (bus.state !== 4'b0100) begin n_bad++; $display("FAIL ped_flag_y got %b want 0100", bus.state); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.hold = 1'b0;
    bus.int_flags = '0;
`ifdef TL_PED_REQ_EN
    bus.ped_req = 1'b0;
`endif
    test_reset;
    test_basic;
    test_full_cycle;
    test_hold;
    test_watchdog;
    test_simultaneous;
`ifdef TL_PED_REQ_EN
    test_ped;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
